// File: rtl/gameplay_input_ctrl_if.sv
// Button and control bundle between the board front end and gameplay.
// master: gameplay_input_ctrl (reads buttons/state_in, drives strobes); slave: gameplay side.
interface gameplay_input_ctrl_if;
    logic        btn_hit;
    logic        btn_left;
    logic        btn_right;
    logic        btn_new_game;
    logic [2:0]  state_in;
    logic        new_game;
    logic        charging_hit;
    logic        camera_pan_left;
    logic        camera_pan_right;
    logic        new_frame;
    logic [15:0] frame_count;

    modport master (
        input  btn_hit,
        input  btn_left,
        input  btn_right,
        input  btn_new_game,
        input  state_in,
        output new_game,
        output charging_hit,
        output camera_pan_left,
        output camera_pan_right,
        output new_frame,
        output frame_count
    );

    modport slave (
        output btn_hit,
        output btn_left,
        output btn_right,
        output btn_new_game,
        output state_in,
        input  new_game,
        input  charging_hit,
        input  camera_pan_left,
        input  camera_pan_right,
        input  new_frame,
        input  frame_count
    );
endinterface

// File: rtl/gameplay_input_ctrl.sv
// Front-end driver for gameplay: sync + debounce of raw buttons, new_game/new_frame
// strobes, camera pan levels and the hit-charge FSM. Ports: clk_in, rst_in, bus (master).
module gameplay_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 742500,
    parameter int FRAME_PERIOD    = 1237500
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    gameplay_input_ctrl_if.master bus
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int FW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [FW-1:0] FR_MAX = FW'(FRAME_PERIOD - 1);

    localparam int B_HIT   = 0;
    localparam int B_LEFT  = 1;
    localparam int B_RIGHT = 2;
    localparam int B_NG    = 3;

    localparam logic [2:0] ST_RESTING = 3'd0;
    localparam logic [2:0] ST_IN_HOLE = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        CHARGING,
        LOCKOUT
    } hit_state_t;

    logic [3:0]    raw;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    stable;
    logic [3:0]    stable_q;
    logic [3:0]    rise;
    logic [3:0]    fall;
    logic [DW-1:0] db_cnt [4];

    logic          power_on;
    logic          ng_evt;
    logic          new_game_q;
    logic [FW-1:0] frame_cnt;
    logic [15:0]   frame_count_q;
    logic          new_frame_w;
    logic          pan_left_q;
    logic          pan_right_q;

    hit_state_t    hit_state;
    hit_state_t    hit_next;
    logic          charging;
    logic          at_rest;
    logic          in_hole;
    logic          hit_quiet;

    assign raw = {bus.btn_new_game, bus.btn_right, bus.btn_left, bus.btn_hit};

    // Sync chain, per-button debounce and registered edge flags.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_q <= '0;
            rise     <= '0;
            fall     <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_MAX) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
            stable_q <= stable;
            rise     <= stable & ~stable_q;
            fall     <= ~stable & stable_q;
        end
    end

    // The power-on flag produces one new_game on the first clock after reset.
    assign ng_evt = power_on | rise[B_NG];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            power_on   <= 1'b1;
            new_game_q <= 1'b0;
        end else begin
            power_on   <= 1'b0;
            new_game_q <= ng_evt;
        end
    end

    // A tick that would coincide with new_game is dropped; the count
    // restarts so the first tick lands FRAME_PERIOD cycles after the pulse.
    assign new_frame_w = (frame_cnt == FR_MAX) & ~new_game_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            frame_cnt     <= '0;
            frame_count_q <= '0;
        end else if (new_game_q) begin
            frame_cnt     <= '0;
            frame_count_q <= '0;
        end else begin
            if (frame_cnt == FR_MAX) begin
                frame_cnt <= '0;
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
            if (new_frame_w) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Pan uses the delayed stable bits so it lines up with the hit path.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pan_left_q  <= 1'b0;
            pan_right_q <= 1'b0;
        end else begin
            pan_left_q  <= stable_q[B_LEFT] & ~stable_q[B_RIGHT];
            pan_right_q <= stable_q[B_RIGHT] & ~stable_q[B_LEFT];
        end
    end

    assign at_rest = (bus.state_in == ST_RESTING);
    assign in_hole = (bus.state_in == ST_IN_HOLE);
    // Released end to end: a press still in the sync chain (e.g. held
    // through reset) must not be mistaken for a release.
    assign hit_quiet = ~stable[B_HIT] & ~sync1[B_HIT] & ~sync2[B_HIT];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_state <= LOCKOUT;
        end else begin
            hit_state <= hit_next;
        end
    end

    always_comb begin
        hit_next = hit_state;
        charging = 1'b0;
        if (ng_evt) begin
            hit_next = LOCKOUT;
        end else begin
            unique case (hit_state)
                IDLE: begin
                    if (rise[B_HIT]) begin
                        hit_next = at_rest ? CHARGING : LOCKOUT;
                    end
                end
                CHARGING: begin
                    if (fall[B_HIT] || in_hole) begin
                        hit_next = LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (hit_quiet && at_rest) begin
                        hit_next = IDLE;
                    end
                end
                default: hit_next = LOCKOUT;
            endcase
        end
        charging = (hit_state == CHARGING);
    end

    assign bus.new_game         = new_game_q;
    assign bus.charging_hit     = charging;
    assign bus.camera_pan_left  = pan_left_q;
    assign bus.camera_pan_right = pan_right_q;
    assign bus.new_frame        = new_frame_w;
    assign bus.frame_count      = frame_count_q;
endmodule

// File: tb/tb_gameplay_input_ctrl.sv
// Scoreboard bench for gameplay_input_ctrl (DEBOUNCE_CYCLES=4, FRAME_PERIOD=10).
// Buttons change 1 time unit after edge c; a press is first sampled at c+1.
module tb_gameplay_input_ctrl;
    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    gameplay_input_ctrl_if bus ();

    gameplay_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .FRAME_PERIOD   (10)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } lvl_t;

    typedef struct {
        int          cyc;
        logic        ng;
        logic [15:0] fc;
    } frm_t;

    lvl_t lq[$];
    frm_t fq[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int ng_cyc   = -1;
    int ng_next  = -1;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Level monitor: {charging_hit, pan_left, pan_right}, compared on change.
    logic [2:0] lvl_prev = 3'b000;
    always @(negedge clk_in) begin : lvl_mon
        logic [2:0] v;
        lvl_t e;
        v = {bus.charging_hit, bus.camera_pan_left, bus.camera_pan_right};
        if (v !== lvl_prev) begin
            checks++;
            if (lq.size() == 0) begin
                failures++;
                $display("FAIL lvl_unexpected cyc=%0d got=%b", cyc, v);
            end else begin
                e = lq.pop_front();
                if (e.cyc != cyc || e.vec !== v) begin
                    failures++;
                    $display("FAIL lvl cyc=%0d got=%b required cyc=%0d vec=%b",
                             cyc, v, e.cyc, e.vec);
                end
            end
            lvl_prev = v;
        end
    end

    // Pulse monitor: new_game / new_frame, frame_count checked next cycle.
    logic        fc_pend = 1'b0;
    logic [15:0] fc_exp  = 16'd0;
    always @(negedge clk_in) begin : frm_mon
        frm_t e;
        logic [1:0] got;
        logic [1:0] want;
        if (fc_pend) begin
            checks++;
            if (bus.frame_count !== fc_exp) begin
                failures++;
                $display("FAIL frame_count cyc=%0d got=%0d required=%0d",
                         cyc, bus.frame_count, fc_exp);
            end
            fc_pend = 1'b0;
        end
        got = {bus.new_game, bus.new_frame};
        if (got != 2'b00) begin
            checks++;
            if (fq.size() == 0) begin
                failures++;
                $display("FAIL pulse_unexpected cyc=%0d ng/nf=%b", cyc, got);
            end else begin
                e    = fq.pop_front();
                want = e.ng ? 2'b10 : 2'b01;
                if (e.cyc != cyc || got !== want) begin
                    failures++;
                    $display("FAIL pulse cyc=%0d ng/nf=%b required cyc=%0d ng/nf=%b",
                             cyc, got, e.cyc, want);
                end
                fc_pend = 1'b1;
                fc_exp  = e.fc;
            end
        end
    end

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic exp_lvl(int c, logic [2:0] v);
        lvl_t e;
        e.cyc = c;
        e.vec = v;
        lq.push_back(e);
    endtask

    // Advance n cycles; expected pulses are queued just before each edge.
    task automatic step(int n);
        for (int i = 0; i < n; i++) begin
            int c;
            frm_t e;
            c = cyc + 1;
            if (c == ng_next) begin
                ng_cyc = c;
                e.cyc  = c;
                e.ng   = 1'b1;
                e.fc   = 16'd0;
                fq.push_back(e);
            end else if (ng_cyc >= 0 && c > ng_cyc && (c - ng_cyc) % 10 == 0) begin
                e.cyc = c;
                e.ng  = 1'b0;
                e.fc  = 16'((c - ng_cyc) / 10);
                fq.push_back(e);
            end
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic at(int c);
        step(c - cyc);
    endtask

    initial begin
        bus.btn_hit      = 1'b0;
        bus.btn_left     = 1'b0;
        bus.btn_right    = 1'b0;
        bus.btn_new_game = 1'b0;
        bus.state_in     = 3'd0;
        #1 rst_in = 1'b1;

        // Reset state, then release: new_game at 3, ticks at 13, 23, 33...
        at(1);
        chk("rst_outputs", 32'({bus.new_game, bus.charging_hit, bus.camera_pan_left,
                                bus.camera_pan_right, bus.new_frame}), 32'd0);
        chk("rst_frame_count", 32'(bus.frame_count), 32'd0);
        at(2);
        rst_in  = 1'b0;
        ng_next = 3;
        at(40);

        // Chatter, then hold: final press at 44 (sampled 45) -> charge at 52.
        bus.btn_hit = 1'b1;
        at(42);
        bus.btn_hit = 1'b0;
        at(44);
        bus.btn_hit = 1'b1;
        exp_lvl(52, 3'b100);
        at(64);
        bus.btn_hit  = 1'b0;
        bus.state_in = 3'd2;
        exp_lvl(72, 3'b000);
        at(76);
        bus.state_in = 3'd0;

        // Press while ball moving, then state returns to rest while held.
        at(80);
        bus.state_in = 3'd3;
        at(82);
        bus.btn_hit = 1'b1;
        at(95);
        bus.state_in = 3'd0;
        at(105);
        chk("held_since_moving", 32'(bus.charging_hit), 32'd0);
        at(110);
        bus.btn_hit = 1'b0;
        at(120);
        bus.btn_hit = 1'b1;
        exp_lvl(128, 3'b100);
        at(130);
        bus.btn_hit = 1'b0;
        exp_lvl(138, 3'b000);

        // Pan at rest, then with the ball moving.
        at(145);
        bus.btn_left = 1'b1;
        exp_lvl(153, 3'b010);
        at(160);
        bus.btn_right = 1'b1;
        exp_lvl(168, 3'b000);
        at(175);
        bus.btn_left = 1'b0;
        exp_lvl(183, 3'b001);
        at(190);
        bus.btn_right = 1'b0;
        exp_lvl(198, 3'b000);
        at(200);
        bus.state_in = 3'd3;
        bus.btn_left = 1'b1;
        exp_lvl(208, 3'b010);
        at(215);
        bus.btn_right = 1'b1;
        exp_lvl(223, 3'b000);
        at(230);
        bus.btn_left = 1'b0;
        exp_lvl(238, 3'b001);
        at(245);
        bus.btn_right = 1'b0;
        exp_lvl(253, 3'b000);

        // New game mid-charge; 283 is also where the old tick would fall.
        at(260);
        bus.state_in = 3'd0;
        bus.btn_hit  = 1'b1;
        exp_lvl(268, 3'b100);
        at(275);
        bus.btn_new_game = 1'b1;
        ng_next          = 283;
        exp_lvl(283, 3'b000);
        at(290);
        bus.btn_new_game = 1'b0;
        at(295);
        bus.btn_hit = 1'b0;

        // Async reset mid-charge, button held through and after reset.
        at(310);
        bus.btn_hit = 1'b1;
        exp_lvl(318, 3'b100);
        at(325);
        #2;
        rst_in  = 1'b1;
        ng_cyc  = -1;
        ng_next = -1;
        exp_lvl(325, 3'b000);
        #1;
        chk("async_rst_outputs", 32'({bus.new_game, bus.charging_hit, bus.camera_pan_left,
                                      bus.camera_pan_right, bus.new_frame}), 32'd0);
        chk("async_rst_frame_count", 32'(bus.frame_count), 32'd0);
        at(330);
        rst_in  = 1'b0;
        ng_next = 331;
        at(350);
        chk("held_through_reset", 32'(bus.charging_hit), 32'd0);
        at(355);
        bus.btn_hit = 1'b0;
        at(380);

        chk("lvl_queue_drained", 32'(lq.size()), 32'd0);
        chk("pulse_queue_drained", 32'(fq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
